// File: rtl/fpu_seq_pkg.sv
// Shared types and opcode constants for the FPU operation sequencer.
package fpu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } seq_state_e;

  localparam logic [3:0] C_FPU_ADD_CMD = 4'h0;
  localparam logic [3:0] C_FPU_SUB_CMD = 4'h1;
  localparam logic [3:0] C_FPU_MUL_CMD = 4'h2;
  localparam logic [3:0] C_FPU_DIV_CMD = 4'h3;
  localparam logic [3:0] C_FPU_NOP_CMD = 4'h7;

  // Request record at the default interface widths.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rm;
    logic [3:0]  op;
    logic [4:0]  tag;
  } fpu_req_t;

endpackage

// File: rtl/fpu_seq_fifo.sv
// Show-ahead request FIFO; head entry is visible on dout whenever !empty.
module fpu_seq_fifo
  import fpu_seq_pkg::*;
#(
  parameter int C_WIDTH = 8,
  parameter int C_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [C_WIDTH-1:0] din,
  output logic [C_WIDTH-1:0] dout,
  output logic               full,
  output logic               empty
);

  localparam int C_PTR = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
  localparam int C_CNT = $clog2(C_DEPTH + 1);

  logic [C_WIDTH-1:0] mem [C_DEPTH];
  logic [C_PTR-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [C_PTR-1:0]   wr_ptr_next, rd_ptr_next;
  logic [C_CNT-1:0]   count_reg;
  logic               do_push, do_pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == C_CNT'(C_DEPTH));

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign wr_ptr_next = (wr_ptr_reg == C_PTR'(C_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
  assign rd_ptr_next = (rd_ptr_reg == C_PTR'(C_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < C_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg == C_PTR'(gi))) begin
          mem[gi] <= din;
        end
      end
    end
  endgenerate

  assign dout = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_next;
      if (do_pop)  rd_ptr_reg <= rd_ptr_next;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Queues FPU requests, issues them one at a time to the FPU wrapper and returns tagged results.
// Optional FPU_SEQ_NOP_FILTER_EN: NOP requests skip the FPU and respond with result 0.
module fpu_op_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int C_OP    = 32,
  parameter int C_RM    = 2,
  parameter int C_CMD   = 4,
  parameter int C_TAG   = 5,
  parameter int C_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [C_OP-1:0]  req_a_i,
  input  logic [C_OP-1:0]  req_b_i,
  input  logic [C_RM-1:0]  req_rm_i,
  input  logic [C_CMD-1:0] req_op_i,
  input  logic [C_TAG-1:0] req_tag_i,
  output logic [C_OP-1:0]  fpu_a_o,
  output logic [C_OP-1:0]  fpu_b_o,
  output logic [C_RM-1:0]  fpu_rm_o,
  output logic [C_CMD-1:0] fpu_op_o,
  output logic             fpu_enable_o,
  output logic             fpu_stall_o,
  input  logic [C_OP-1:0]  fpu_result_i,
  input  logic             fpu_result_valid_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [C_OP-1:0]  rsp_result_o,
  output logic [C_TAG-1:0] rsp_tag_o,
  output logic             busy_o
);

  localparam int C_REQ_W = 2 * C_OP + C_RM + C_CMD + C_TAG;

  seq_state_e state_reg, state_next;

  logic [C_REQ_W-1:0] fifo_din, fifo_dout;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;

  logic [C_OP-1:0]  head_a, head_b;
  logic [C_RM-1:0]  head_rm;
  logic [C_CMD-1:0] head_op;
  logic [C_TAG-1:0] head_tag;
  logic             head_nop;

  logic [C_OP-1:0]  iss_a_reg, iss_b_reg;
  logic [C_RM-1:0]  iss_rm_reg;
  logic [C_CMD-1:0] iss_op_reg;
  logic [C_TAG-1:0] iss_tag_reg;

  logic             rsp_valid_reg;
  logic [C_OP-1:0]  rsp_result_reg;
  logic [C_TAG-1:0] rsp_tag_reg;

  logic rsp_free;
  logic load_issue, load_rsp_fpu, load_rsp_nop;

  assign fifo_din    = {req_a_i, req_b_i, req_rm_i, req_op_i, req_tag_i};
  assign fifo_push   = req_valid_i && !fifo_full;
  assign req_ready_o = !fifo_full;

  assign {head_a, head_b, head_rm, head_op, head_tag} = fifo_dout;

  fpu_seq_fifo #(
    .C_WIDTH (C_REQ_W),
    .C_DEPTH (C_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef FPU_SEQ_NOP_FILTER_EN
  assign head_nop = (head_op == C_CMD'(C_FPU_NOP_CMD));
`else
  assign head_nop = 1'b0;
`endif

  // The response register can take a new value if it is empty or drains this cycle.
  assign rsp_free = !rsp_valid_reg || rsp_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    fifo_pop     = 1'b0;
    load_issue   = 1'b0;
    load_rsp_fpu = 1'b0;
    load_rsp_nop = 1'b0;
    fpu_enable_o = 1'b0;
    fpu_stall_o  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty && rsp_free) begin
          fifo_pop = 1'b1;
          if (head_nop) begin
            load_rsp_nop = 1'b1;
          end else begin
            load_issue = 1'b1;
            state_next = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        fpu_enable_o = 1'b1;
        if (rsp_valid_reg && !rsp_ready_i) begin
          fpu_stall_o = 1'b1;
          state_next  = ST_HOLD;
        end else if (fpu_result_valid_i) begin
          load_rsp_fpu = 1'b1;
          // Chain the next request straight into ISSUE so windows stay contiguous.
          if (!fifo_empty && !head_nop) begin
            fifo_pop   = 1'b1;
            load_issue = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        fpu_enable_o = 1'b1;
        fpu_stall_o  = 1'b1;
        if (rsp_free) begin
          state_next = ST_ISSUE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Issue register only changes on a pop into ISSUE, so FPU inputs stay quiet in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_a_reg   <= '0;
      iss_b_reg   <= '0;
      iss_rm_reg  <= '0;
      iss_op_reg  <= '0;
      iss_tag_reg <= '0;
    end else if (load_issue) begin
      iss_a_reg   <= head_a;
      iss_b_reg   <= head_b;
      iss_rm_reg  <= head_rm;
      iss_op_reg  <= head_op;
      iss_tag_reg <= head_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg  <= 1'b0;
      rsp_result_reg <= '0;
      rsp_tag_reg    <= '0;
    end else if (load_rsp_fpu) begin
      rsp_valid_reg  <= 1'b1;
      rsp_result_reg <= fpu_result_i;
      rsp_tag_reg    <= iss_tag_reg;
    end else if (load_rsp_nop) begin
      rsp_valid_reg  <= 1'b1;
      rsp_result_reg <= '0;
      rsp_tag_reg    <= head_tag;
    end else if (rsp_ready_i) begin
      rsp_valid_reg  <= 1'b0;
    end
  end

  assign fpu_a_o      = iss_a_reg;
  assign fpu_b_o      = iss_b_reg;
  assign fpu_rm_o     = iss_rm_reg;
  assign fpu_op_o     = iss_op_reg;
  assign rsp_valid_o  = rsp_valid_reg;
  assign rsp_result_o = rsp_result_reg;
  assign rsp_tag_o    = rsp_tag_reg;
  assign busy_o       = !fifo_empty || (state_reg != ST_IDLE);

endmodule
